// File: rtl/brent_kung_unadder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | brent_kung_unadder_if                                                    |
// | Operand/result handshake bundle for the digit-serial adder inverse.      |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
interface brent_kung_unadder_if #(
  parameter int WIDTH = 12
);
  logic [WIDTH:0]   sum_in;
  logic [WIDTH-1:0] addend_in;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] diff_out;
  logic             error;
  logic             check_fail;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output sum_in, addend_in, in_valid, out_ready,
    input  in_ready, diff_out, error, check_fail, out_valid
  );

  modport slave (
    input  sum_in, addend_in, in_valid, out_ready,
    output in_ready, diff_out, error, check_fail, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/brent_kung_unadder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | brent_kung_unadder                                                       |
// | Recovers addend = sum - known_addend, DIGIT bits per clock, flags sums   |
// | no WIDTH-bit addend could produce. UNADDER_ROUNDTRIP_CHECK_EN adds a     |
// | one-cycle re-add check state.                                            |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module brent_kung_unadder #(
  parameter int WIDTH = 12,
  parameter int DIGIT = 4
) (
  input wire                   clk,
  input wire                   rst,
  brent_kung_unadder_if.slave  bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_CHECK = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   sum_q, sum_d;
  logic [WIDTH-1:0] addend_q, addend_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             error_q, error_d;

  logic [31:0]      lsb_idx;
  logic [DIGIT:0]   sub_res;

  assign lsb_idx = 32'(cnt_q) * 32'(DIGIT);

  // One DIGIT-wide subtract per cycle; the extra MSB is the borrow-out.
  assign sub_res = {1'b0, sum_q[lsb_idx +: DIGIT]}
                 - {1'b0, addend_q[lsb_idx +: DIGIT]}
                 - {{DIGIT{1'b0}}, borrow_q};

`ifdef UNADDER_ROUNDTRIP_CHECK_EN
  logic             check_fail_q, check_fail_d;
  logic [WIDTH:0]   roundtrip;

  assign roundtrip = {1'b0, diff_q} + {1'b0, addend_q};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sum_q        <= '0;
      addend_q     <= '0;
      diff_q       <= '0;
      borrow_q     <= 1'b0;
      cnt_q        <= '0;
      error_q      <= 1'b0;
`ifdef UNADDER_ROUNDTRIP_CHECK_EN
      check_fail_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sum_q        <= sum_d;
      addend_q     <= addend_d;
      diff_q       <= diff_d;
      borrow_q     <= borrow_d;
      cnt_q        <= cnt_d;
      error_q      <= error_d;
`ifdef UNADDER_ROUNDTRIP_CHECK_EN
      check_fail_q <= check_fail_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    sum_d        = sum_q;
    addend_d     = addend_q;
    diff_d       = diff_q;
    borrow_d     = borrow_q;
    cnt_d        = cnt_q;
    error_d      = error_q;
`ifdef UNADDER_ROUNDTRIP_CHECK_EN
    check_fail_d = check_fail_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          sum_d    = bus.sum_in;
          addend_d = bus.addend_in;
          borrow_d = 1'b0;
          cnt_d    = '0;
          error_d  = 1'b0;
`ifdef UNADDER_ROUNDTRIP_CHECK_EN
          check_fail_d = 1'b0;
`endif
          state_d  = S_CALC;
        end
      end

      S_CALC: begin
        diff_d[lsb_idx +: DIGIT] = sub_res[DIGIT-1:0];
        borrow_d = sub_res[DIGIT];
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          // Top bit t = sum[WIDTH] - borrow must be 0 for a valid addend.
          error_d = sub_res[DIGIT] ^ sum_q[WIDTH];
          cnt_d   = '0;
`ifdef UNADDER_ROUNDTRIP_CHECK_EN
          state_d = S_CHECK;
`else
          state_d = S_HOLD;
`endif
        end
      end

`ifdef UNADDER_ROUNDTRIP_CHECK_EN
      S_CHECK: begin
        check_fail_d = (roundtrip != sum_q) & ~error_q;
        state_d      = S_HOLD;
      end
`endif

      S_HOLD: begin
        if (bus.out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_HOLD);
  assign bus.diff_out  = diff_q;
  assign bus.error     = error_q;
`ifdef UNADDER_ROUNDTRIP_CHECK_EN
  assign bus.check_fail = check_fail_q;
`else
  assign bus.check_fail = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_brent_kung_unadder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_brent_kung_unadder                                                    |
// | Scoreboard bench: directed vectors, back-pressure, reset, random sweep.  |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_brent_kung_unadder;

`ifdef UNADDER_ROUNDTRIP_CHECK_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  typedef struct packed {
    logic [11:0] diff;
    logic        err;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   n_push;
  int   n_out;
  logic throttle;
  exp_t exp_q[$];

  brent_kung_unadder_if #(.WIDTH(12)) bus ();

  brent_kung_unadder #(.WIDTH(12), .DIGIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Returns one step after the accepting edge.
  task automatic send(input logic [12:0] s, input logic [11:0] a,
                      input logic [11:0] exp_diff, input logic exp_err);
    int   guard;
    logic acc;
    exp_t e;
    guard = 0;
    bus.sum_in    = s;
    bus.addend_in = a;
    bus.in_valid  = 1'b1;
    do begin
      @(negedge clk);
      acc = bus.in_ready;
      guard++;
    end while (!acc && guard < 400);
    if (!acc) begin
      check("accept_timeout", 32'd0, 32'd1);
      bus.in_valid = 1'b0;
    end else begin
      e.diff = exp_diff;
      e.err  = exp_err;
      exp_q.push_back(e);
      n_push++;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 400) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  // Output monitor: a handshake seen here completes at the next rising edge.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        check("unexpected_out", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("diff", 32'(bus.diff_out), 32'(e.diff));
        check("error", 32'(bus.error), 32'(e.err));
        check("check_fail", 32'(bus.check_fail), 32'd0);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (throttle) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    int first;
    n_checks = 0; n_errors = 0; n_push = 0; n_out = 0;
    throttle      = 1'b0;
    rst           = 1'b1;
    bus.sum_in    = '0;
    bus.addend_in = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_diff", 32'(bus.diff_out), 32'd0);
    check("rst_error", 32'(bus.error), 32'd0);
    check("rst_check_fail", 32'(bus.check_fail), 32'd0);
    @(posedge clk);
    #1;

    // Basic vector with latency measurement
    send(13'h1000, 12'h001, 12'hFFF, 1'b0);
    first = 0;
    for (int k = 1; k <= LAT + 3; k++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid && first == 0) first = k;
    end
    check("latency", first, LAT);
    drain();

    send(13'h0005, 12'h007, 12'hFFE, 1'b1);
    drain();
    send(13'h1FFF, 12'h000, 12'hFFF, 1'b1);
    drain();
    send(13'h1FFE, 12'hFFF, 12'hFFF, 1'b0);
    drain();

    // Back-pressure: result held, new operands ignored
    bus.out_ready = 1'b0;
    send(13'h0ABC, 12'h123, 12'h999, 1'b0);
    repeat (LAT + 1) @(posedge clk);
    #1;
    bus.sum_in    = 13'h0777;
    bus.addend_in = 12'h111;
    bus.in_valid  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_diff", 32'(bus.diff_out), 32'h999);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_in_ready_hs", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    check("bp_in_ready_after", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    drain();

    // Reset on the second CALC cycle discards the operation
    send(13'h0FFF, 12'h001, 12'hFFE, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    n_push--;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_diff", 32'(bus.diff_out), 32'd0);
    send(13'h0800, 12'h400, 12'h400, 1'b0);
    drain();

    // Random sweep with throttled consumer
    throttle = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      logic [11:0] a;
      logic [11:0] b;
      a = 12'($urandom_range(0, 4095));
      b = 12'($urandom_range(0, 4095));
      send({1'b0, a} + {1'b0, b}, b, a, 1'b0);
    end
    throttle = 1'b0;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    drain();
    repeat (LAT + 2) @(posedge clk);
    check("out_count", n_out, n_push);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
